send_sched: RTL
===============

# send_sched

Traffic scheduler for the four-node packet sender. It drives `send_en[3:0]` and `curr_node[1:0]` to walk the destination through nodes 0→1→2→3. For each destination, it injects exactly `pkt_num` packets from each of the three other nodes, counting acceptances on the sender's registered `pesi` strobes. It sits between the test/config logic (start, packet count) and the sender, and reports completion, total packets and errors.

## Interface
- `PKTS_W`, 8: width of `pkt_num` and of the per-source counters.
- `DRAIN_CYC`, 4: idle cycles with all `send_en` low between destinations, letting in-flight ring traffic settle.
- `TIMEOUT`, 1024: number of cycles in RUN with no `pesi` before aborting.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted at 0).
- `start` in 1: one-cycle start strobe; sampled only in IDLE or DONE.
- `pkt_num` in PKTS_W: packets per source per destination; latched on an accepted start.
- `pesi` in 4: per-node inject strobes from the sender, `{node3..node0}`.
- `send_en` out 4: per-source enable to the sender; combinational.
- `curr_node` out 2: current destination node; registered.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: level, high in DONE.
- `err` out 1: sticky error flag; cleared by reset or an accepted start.
- `tx_total` out PKTS_W+4: packets counted since the last accepted start.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **IDLE/DONE**
  - `start`=1 with `pkt_num`≠0: latch N=`pkt_num`, clear `cnt[0..3]`, `tx_total`, `err` and the stall counter; set `curr_node`=0; enter RUN.
  - `start` with `pkt_num`=0 is ignored; state is unchanged.
- **RUN**
  - `send_en[i] = (i != curr_node) && (cnt[i] + pesi[i] < N)`.
  - The sum is computed in PKTS_W+1 bits.
  - Because `pesi[i]` is the result of the previous cycle's enable, the sender issues exactly N packets per source; there is no overshoot.
  - On `pesi[i]`=1 with `i != curr_node`: `cnt[i]`++ and `tx_total`++.
  - Phase is complete when `cnt[i]`==N for all three `i != curr_node`. Then enter DRAIN and clear the drain counter.
- **DRAIN**
  - `send_en`=0.
  - After DRAIN_CYC cycles:
    - if `curr_node`==3, enter DONE;
    - otherwise `curr_node`++, clear all `cnt`, clear the stall counter, and enter RUN.
- **Unexpected strobes**
  - `pesi[i]`=1 in any state other than RUN, or `pesi[curr_node]`=1 in RUN, sets `err`.
  - Such a strobe is not counted, and the state does not change.
- **Timeout**
  - In RUN, the stall counter increments each cycle with `pesi`==0 and clears on any counted `pesi`.
  - When it reaches TIMEOUT: set `err`, force `send_en`=0, enter DONE. `curr_node` and `tx_total` hold for debug.
- **Other rules**
  - `start` in RUN or DRAIN is ignored.
  - A completed run leaves `tx_total` = 12·N.

## Timing
- **Reset values:** state IDLE, `send_en`=0, `curr_node`=0, `busy`=0, `done`=0, `err`=0, `tx_total`=0, all counters 0.
- **Reset response:** assertion takes effect immediately (asynchronous). `send_en` drops in the same cycle because it is decoded from state.
- **Reset mid-run:** reset during RUN or DRAIN returns to IDLE with no further enables. The sender may still show one `pesi` the next cycle; this must not set `err`, so `err` ignores `pesi` during the first cycle after reset release.
- **Start latency:** `start` sampled at edge t → RUN from t; `send_en` is asserted during cycle t+1. The first `pesi` can arrive at t+2, subject to sender `peri`/`polarity`.
- **Phase-end latency:** the last counted `pesi` at edge t → DRAIN from t (`send_en` already 0 at t). The next RUN or DONE follows DRAIN_CYC cycles later.
- **Outputs:** `busy` and `done` are decoded from registered state. `tx_total` is updated on the edge that counts the strobe.
- **Back-pressure:** `send_en` may stay high while the sender withholds `pesi` (`peri` low or polarity mismatch); only the stall counter advances.
- **Counter widths:** `tx_total` does not wrap, since 12·(2^PKTS_W−1) fits in PKTS_W+4 bits.

## Test plan
- **Full run, no back-pressure.** Sender model that strobes `pesi` on every enabled cycle, `pkt_num`=3, `start` → destinations 0,1,2,3 in order. Each source gets exactly 3 strobes per destination, `send_en[curr_node]` is never high, DRAIN gaps are 4 cycles, then `done`=1, `tx_total`=36, `err`=0.
- **Random back-pressure.** `pesi` withheld randomly ~50%, `pkt_num`=5 → no source exceeds 5 per phase, `tx_total`=60, `err`=0.
- **Stall timeout.** `pesi` held 0 with TIMEOUT=16 → `err`=1 and DONE 16 cycles into RUN, `send_en`=0, `curr_node`=0.
- **Spurious strobe.** `pesi[2]` forced high in IDLE, and `pesi[curr_node]` forced high during RUN → `err`=1, counts unaffected.
- **Reset mid-phase.** `reset`=0 during destination 2 → all outputs at reset values immediately. A restart with `pkt_num`=1 completes with `tx_total`=12.
- **Ignored starts.** `start` during RUN is ignored; `start` with `pkt_num`=0 in IDLE stays in IDLE.

Source files
------------

// File: rtl/send_sched.sv
// Destination walker for the four-node packet sender: injects N packets from
// each of the other three nodes into every destination, counting sender strobes.
module send_sched #(
  parameter int unsigned PKTS_W    = 8,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PKTS_W-1:0] pkt_num,
  input  logic [3:0]        pesi,
  output logic [3:0]        send_en,
  output logic [1:0]        curr_node,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PKTS_W+3:0] tx_total
);

  localparam int unsigned TOT_W   = PKTS_W + 4;
  localparam int unsigned SUM_W   = PKTS_W + 1;
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PKTS_W-1:0]  n_q;
  logic [PKTS_W-1:0]  cnt [4];
  logic [STALL_W-1:0] stall;
  logic [DRAIN_W-1:0] drain;
  logic               armed_q;

  logic               start_ok;
  logic               phase_full;
  logic               stall_out;
  logic               drain_last;
  logic               stray;
  logic [3:0]         cnt_hit;
  logic [1:0]         hit_sum;

  // Event decode shared by the FSM and the datapath
  always_comb begin
    start_ok   = start && (pkt_num != '0) && ((state == S_IDLE) || (state == S_DONE));
    cnt_hit    = '0;
    phase_full = (state == S_RUN);
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != curr_node) begin
        cnt_hit[i] = (state == S_RUN) && pesi[i];
        if ((SUM_W'(cnt[i]) + SUM_W'(cnt_hit[i])) != SUM_W'(n_q)) phase_full = 1'b0;
      end
    end
    hit_sum    = 2'(cnt_hit[0]) + 2'(cnt_hit[1]) + 2'(cnt_hit[2]) + 2'(cnt_hit[3]);
    stray      = (state == S_RUN) ? pesi[curr_node] : (pesi != '0);
    stall_out  = (state == S_RUN) && (pesi == '0) && (stall == STALL_W'(TIMEOUT - 1));
    drain_last = (drain == DRAIN_W'(DRAIN_CYC - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = S_RUN;
      S_RUN: begin
        if (phase_full)     state_nxt = S_DRAIN;
        else if (stall_out) state_nxt = S_DONE;
      end
      S_DRAIN: if (drain_last) state_nxt = (curr_node == 2'd3) ? S_DONE : S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Enables look one strobe ahead since pesi lags send_en by a cycle
  always_comb begin
    send_en = '0;
    busy    = (state == S_RUN) || (state == S_DRAIN);
    done    = (state == S_DONE);
    if (state == S_RUN) begin
      for (int i = 0; i < 4; i++) begin
        send_en[i] = (2'(i) != curr_node) &&
                     ((SUM_W'(cnt[i]) + SUM_W'(pesi[i])) < SUM_W'(n_q));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q       <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      stall     <= '0;
      drain     <= '0;
      armed_q   <= 1'b0;
      curr_node <= '0;
      err       <= 1'b0;
      tx_total  <= '0;
    end else begin
      armed_q <= 1'b1;
      // The sender can echo one stale strobe right after reset release
      if (armed_q && stray) err <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            n_q       <= pkt_num;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            stall     <= '0;
            curr_node <= '0;
            err       <= 1'b0;
            tx_total  <= '0;
          end
        end
        S_RUN: begin
          for (int i = 0; i < 4; i++) begin
            if (cnt_hit[i]) cnt[i] <= cnt[i] + PKTS_W'(1);
          end
          tx_total <= tx_total + TOT_W'(hit_sum);
          if (cnt_hit != '0)   stall <= '0;
          else if (pesi == '0) stall <= stall + STALL_W'(1);
          if (phase_full) drain <= '0;
          if (stall_out)  err   <= 1'b1;
        end
        S_DRAIN: begin
          drain <= drain + DRAIN_W'(1);
          if (drain_last && (curr_node != 2'd3)) begin
            curr_node <= curr_node + 2'd1;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            stall     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
